// File: rtl/tnn_popcount_seq_if.sv
// Handshake bundle for the ternary-neuron popcount sequencer: input
// transaction (activations, masks, threshold) and signed result.
interface tnn_popcount_seq_if #(
    parameter int unsigned N_CHUNKS = 4,
    parameter int unsigned ACC_W    = 8
);
    localparam int unsigned IN_W  = 25 * N_CHUNKS;
    localparam int unsigned SUM_W = ACC_W + 1;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_x;
    logic [IN_W-1:0]  in_wpos;
    logic [IN_W-1:0]  in_wneg;
    logic [SUM_W-1:0] in_thr;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic             out_act;

    // Producer/consumer side (sensor interface and downstream stage)
    modport master (
        output in_valid, in_x, in_wpos, in_wneg, in_thr, out_ready,
        input  in_ready, out_valid, out_sum, out_act
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_x, in_wpos, in_wneg, in_thr, out_ready,
        output in_ready, out_valid, out_sum, out_act
    );
endinterface

// File: rtl/tnn_popcount_seq.sv
// Ternary neuron sequencer: time-shares one external 25-input popcount unit
// over N_CHUNKS chunks (positive then negative pass each) and thresholds the sum.
module tnn_popcount_seq #(
    parameter int unsigned N_CHUNKS = 4,
    parameter int unsigned ACC_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tnn_popcount_seq_if.slave    bus,
    output logic [24:0]          pc_in,
    input  logic [4:0]           pc_out
);
    localparam int unsigned CHUNK_W   = 25;
    localparam int unsigned IN_W      = CHUNK_W * N_CHUNKS;
    localparam int unsigned SUM_W     = ACC_W + 1;
    localparam int unsigned CH_W      = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int unsigned STEP_W    = CH_W + 1;
    localparam int unsigned LAST_STEP = 2 * N_CHUNKS - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [STEP_W-1:0]  step_q;
    logic [IN_W-1:0]    x_q, wpos_q, wneg_q;
    logic [SUM_W-1:0]   thr_q;
    logic [ACC_W-1:0]   pos_acc_q, neg_acc_q;
    logic [ACC_W-1:0]   pos_acc_d, neg_acc_d;
    logic               out_valid_q;
    logic [SUM_W-1:0]   out_sum_q;
    logic               out_act_q;

    logic               accept;
    logic               run_en;
    logic               last_step;
    logic [SUM_W-1:0]   sum_d;
    logic               act_d;

    logic [CHUNK_W-1:0] x_ch    [N_CHUNKS];
    logic [CHUNK_W-1:0] wpos_ch [N_CHUNKS];
    logic [CHUNK_W-1:0] wneg_ch [N_CHUNKS];
    logic [CH_W-1:0]    chunk;
    logic [CHUNK_W-1:0] x_c, wpos_c, wneg_c;

    // Slice latched vectors into chunk views; chunk k = bits [25k+24:25k]
    for (genvar k = 0; k < N_CHUNKS; k++) begin : g_chunk
        assign x_ch[k]    = x_q[k*CHUNK_W +: CHUNK_W];
        assign wpos_ch[k] = wpos_q[k*CHUNK_W +: CHUNK_W];
        assign wneg_ch[k] = wneg_q[k*CHUNK_W +: CHUNK_W];
    end

    assign chunk  = step_q[STEP_W-1:1];
    assign x_c    = x_ch[chunk];
    assign wpos_c = wpos_ch[chunk];
    assign wneg_c = wneg_ch[chunk];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state, popcount operand and accumulator updates
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        run_en    = 1'b0;
        last_step = 1'b0;
        pc_in     = '0;
        pos_acc_d = pos_acc_q;
        neg_acc_d = neg_acc_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                run_en = 1'b1;
                // Bits set in both masks carry weight 0 and drop out of both passes
                if (step_q[0]) begin
                    pc_in     = x_c & wneg_c & ~wpos_c;
                    neg_acc_d = neg_acc_q + ACC_W'(pc_out);
                end else begin
                    pc_in     = x_c & wpos_c & ~wneg_c;
                    pos_acc_d = pos_acc_q + ACC_W'(pc_out);
                end
                if (step_q == STEP_W'(LAST_STEP)) begin
                    last_step = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sum_d = SUM_W'(pos_acc_d) - SUM_W'(neg_acc_d);
    assign act_d = ($signed(sum_d) >= $signed(thr_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q      <= '0;
            x_q         <= '0;
            wpos_q      <= '0;
            wneg_q      <= '0;
            thr_q       <= '0;
            pos_acc_q   <= '0;
            neg_acc_q   <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_act_q   <= 1'b0;
        end else begin
            out_valid_q <= (state_d == DONE);
            if (accept) begin
                x_q       <= bus.in_x;
                wpos_q    <= bus.in_wpos;
                wneg_q    <= bus.in_wneg;
                thr_q     <= bus.in_thr;
                step_q    <= '0;
                pos_acc_q <= '0;
                neg_acc_q <= '0;
            end else if (run_en) begin
                step_q    <= step_q + STEP_W'(1);
                pos_acc_q <= pos_acc_d;
                neg_acc_q <= neg_acc_d;
                if (last_step) begin
                    out_sum_q <= sum_d;
                    out_act_q <= act_d;
                end
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_act   = out_act_q;

endmodule

// File: tb/tb_tnn_popcount_seq.sv
// Directed self-checking bench for tnn_popcount_seq with an exact or
// approximate popcount stub on the pc_in/pc_out side.
module tb_tnn_popcount_seq;
    localparam int unsigned N_CHUNKS = 4;
    localparam int unsigned ACC_W    = 8;
    localparam int unsigned IN_W     = 100;
    localparam int unsigned SUM_W    = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [24:0]      pc_in;
    logic [4:0]       pc_out;
    int               stub_mode = 0;
    logic             stub_even = 1'b0;
    int               stub_cnt;
    int               checks = 0;
    int               failures = 0;

    logic [IN_W-1:0]  all1;
    logic [IN_W-1:0]  zero;

    always #5 clk = ~clk;

    tnn_popcount_seq_if #(.N_CHUNKS(N_CHUNKS), .ACC_W(ACC_W)) bus ();

    tnn_popcount_seq #(.N_CHUNKS(N_CHUNKS), .ACC_W(ACC_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave),
        .pc_in  (pc_in),
        .pc_out (pc_out)
    );

    // Popcount stub: 0 exact, 1 +1 every step, 2 +1 on even steps only
    always_comb begin
        stub_cnt = $countones(pc_in);
        if (stub_mode == 1 || (stub_mode == 2 && stub_even)) stub_cnt = stub_cnt + 1;
        if (stub_cnt > 31) stub_cnt = 31;
        pc_out = 5'(stub_cnt);
    end

    function automatic logic [24:0] exp_pc(input logic [IN_W-1:0] x, wp, wn, input int step);
        logic [24:0] xc, pc, nc;
        int c;
        c  = step / 2;
        xc = x[c*25 +: 25];
        pc = wp[c*25 +: 25];
        nc = wn[c*25 +: 25];
        return (step % 2 == 0) ? (xc & pc & ~nc) : (xc & nc & ~pc);
    endfunction

    task automatic accept_txn(input logic [IN_W-1:0] x, wp, wn, input logic [SUM_W-1:0] thr,
                              input string name, output bit ok);
        int waited;
        ok = 1'b1;
        @(negedge clk);
        bus.in_x = x; bus.in_wpos = wp; bus.in_wneg = wn; bus.in_thr = thr;
        bus.in_valid = 1'b1;
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            checks++; failures++;
            $display("FAIL %s accept_timeout in_ready=%b required=1", name, bus.in_ready);
            bus.in_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_x = ~x; bus.in_wpos = ~wp; bus.in_wneg = ~wn; bus.in_thr = ~thr;
    endtask

    task automatic run_txn(input logic [IN_W-1:0] x, wp, wn, input logic [SUM_W-1:0] thr,
                           input logic [SUM_W-1:0] exp_sum, input logic exp_act, input string name);
        bit ok;
        accept_txn(x, wp, wn, thr, name, ok);
        if (!ok) return;
        for (int i = 0; i < 2*N_CHUNKS; i++) begin
            stub_even = (i % 2 == 0);
            @(negedge clk);
            checks++;
            if (pc_in !== exp_pc(x, wp, wn, i)) begin
                failures++;
                $display("FAIL %s pc_in step=%0d got=%h required=%h", name, i, pc_in, exp_pc(x, wp, wn, i));
            end
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s run_flags step=%0d out_valid=%b in_ready=%b required=0,0",
                         name, i, bus.out_valid, bus.in_ready);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s out_valid got=%b required=1", name, bus.out_valid);
        end
        checks++;
        if (bus.out_sum !== exp_sum) begin
            failures++;
            $display("FAIL %s out_sum got=%h required=%h", name, bus.out_sum, exp_sum);
        end
        checks++;
        if (bus.out_act !== exp_act) begin
            failures++;
            $display("FAIL %s out_act got=%b required=%b", name, bus.out_act, exp_act);
        end
    endtask

    task automatic release_out(input logic [SUM_W-1:0] exp_sum, input string name);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_sum !== exp_sum) begin
            failures++;
            $display("FAIL %s release out_valid=%b in_ready=%b out_sum=%h required=0,1,%h",
                     name, bus.out_valid, bus.in_ready, bus.out_sum, exp_sum);
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || pc_in !== 25'h0 || bus.in_ready !== 1'b1 ||
            bus.out_sum !== 9'h0 || bus.out_act !== 1'b0) begin
            failures++;
            $display("FAIL reset_values out_valid=%b pc_in=%h in_ready=%b out_sum=%h out_act=%b required=0,0,1,0,0",
                     bus.out_valid, pc_in, bus.in_ready, bus.out_sum, bus.out_act);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d in_ready=%b out_valid=%b required=1,0",
                         i, bus.in_ready, bus.out_valid);
            end
        end
    endtask

    task automatic test_full_pos();
        run_txn(all1, all1, zero, 9'd100, 9'd100, 1'b1, "full_pos");
        release_out(9'd100, "full_pos");
    endtask

    task automatic test_full_neg();
        run_txn(all1, zero, all1, 9'h19D, 9'h19C, 1'b0, "full_neg_thr_m99");
        release_out(9'h19C, "full_neg_thr_m99");
        run_txn(all1, zero, all1, 9'h19C, 9'h19C, 1'b1, "full_neg_thr_m100");
        release_out(9'h19C, "full_neg_thr_m100");
    endtask

    task automatic test_overlap();
        run_txn(all1, all1, all1, 9'h000, 9'h000, 1'b1, "overlap");
        release_out(9'h000, "overlap");
    endtask

    task automatic test_mixed();
        logic [IN_W-1:0] x, wp, wn;
        x  = {25'h1FFFFFF, 25'h0000000, 25'h0F0F0F0, 25'h1FFFFFF};
        wp = {25'h0000000, 25'h1555555, 25'h1FFFFFF, 25'h0000FFF};
        wn = {25'h0000007, 25'h0AAAAAA, 25'h00000FF, 25'h0000000};
        run_txn(x, wp, wn, 9'd17, 9'd17, 1'b1, "mixed_thr17");
        release_out(9'd17, "mixed_thr17");
        run_txn(x, wp, wn, 9'd18, 9'd17, 1'b0, "mixed_thr18");
        release_out(9'd17, "mixed_thr18");
    endtask

    task automatic test_backpressure();
        run_txn(all1, all1, zero, 9'd50, 9'd100, 1'b1, "bp");
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.in_valid = 1'b1;
                bus.in_x = all1; bus.in_wpos = zero; bus.in_wneg = all1; bus.in_thr = 9'h0;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_sum !== 9'd100 || bus.out_act !== 1'b1 ||
                bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d out_valid=%b out_sum=%h out_act=%b in_ready=%b required=1,064,1,0",
                         i, bus.out_valid, bus.out_sum, bus.out_act, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        release_out(9'd100, "bp");
        run_txn(all1, zero, all1, 9'h19C, 9'h19C, 1'b1, "bp_next");
        release_out(9'h19C, "bp_next");
    endtask

    task automatic test_approx();
        logic [IN_W-1:0] wp;
        wp = {4{25'h00000FF}};
        stub_mode = 1;
        run_txn(all1, wp, ~wp, 9'h000, 9'h1DC, 1'b0, "approx_all_plus1");
        release_out(9'h1DC, "approx_all_plus1");
        stub_mode = 2;
        run_txn(all1, wp, ~wp, 9'h1E0, 9'h1E0, 1'b1, "approx_even_plus1");
        release_out(9'h1E0, "approx_even_plus1");
        stub_mode = 0;
        stub_even = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        bit seen;
        accept_txn(all1, zero, all1, 9'h0, "mid_reset", ok);
        if (!ok) return;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || pc_in !== 25'h0 || bus.in_ready !== 1'b1 || bus.out_sum !== 9'h0) begin
            failures++;
            $display("FAIL mid_reset_values out_valid=%b pc_in=%h in_ready=%b out_sum=%h required=0,0,1,0",
                     bus.out_valid, pc_in, bus.in_ready, bus.out_sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL mid_reset_no_output out_valid_seen=1 required=0");
        end
        run_txn(all1, all1, zero, 9'd100, 9'd100, 1'b1, "after_mid_reset");
        release_out(9'd100, "after_mid_reset");
    endtask

    initial begin
        all1 = '1;
        zero = '0;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_wpos   = '0;
        bus.in_wneg   = '0;
        bus.in_thr    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_full_pos();
        test_full_neg();
        test_overlap();
        test_mixed();
        test_backpressure();
        test_approx();
        test_reset_mid_run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
